// File: rtl/hazard_forward_unit_if.sv
// rtl/hazard_forward_unit_if.sv - ID-stage request and hazard/forward control bundle
//
// Groups everything between the pipeline datapath and the hazard unit
// except clk and reset.
//   master : pipeline side. Drives the ID fields and ex_redirect.
//            Receives the forwarding selects, bypass, stall, flushes and counters.
//   slave  : hazard unit side. Mirror image of master.
// Signals:
//   id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt : instruction currently in ID
//   id_dest, id_regwrite, id_memread               : its write-back info
//   ex_redirect                                    : taken branch/jump resolved in EX
//   fwd_a_sel, fwd_b_sel                           : EX operand mux selects
//   id_bypass_a, id_bypass_b                       : ID read takes WB write data
//   stall, flush_ifid, flush_idex                  : pipeline control
//   stall_count, flush_count                       : saturating event counters

interface hazard_forward_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [REG_AW-1:0] id_dest;
  logic              id_regwrite;
  logic              id_memread;
  logic              ex_redirect;

  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              id_bypass_a;
  logic              id_bypass_b;
  logic              stall;
  logic              flush_ifid;
  logic              flush_idex;
  logic [CNT_W-1:0]  stall_count;
  logic [CNT_W-1:0]  flush_count;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_dest, id_regwrite, id_memread, ex_redirect,
    input  fwd_a_sel, fwd_b_sel, id_bypass_a, id_bypass_b,
           stall, flush_ifid, flush_idex, stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_dest, id_regwrite, id_memread, ex_redirect,
    output fwd_a_sel, fwd_b_sel, id_bypass_a, id_bypass_b,
           stall, flush_ifid, flush_idex, stall_count, flush_count
  );

endinterface

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - load-use stall, operand forwarding, ID bypass and redirect flush
//
// Keeps a shadow copy of the instructions in EX, MEM and WB.
// All hazard decisions are made from that shadow copy plus the ID-stage fields.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   hz    : hazard_forward_unit_if.slave.
//           Carries the ID-stage fields and ex_redirect in.
//           Carries the forwarding selects, ID bypass, stall, flushes and saturating counters out.

module hazard_forward_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input logic                  clk,
  input logic                  reset,
  hazard_forward_unit_if.slave hz
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              uses_rs;
    logic              uses_rt;
    logic [REG_AW-1:0] dest;
    logic              regwrite;
    logic              memread;
  } stage_t;

  stage_t ex_q, ex_d;
  stage_t mem_q;
  stage_t wb_q;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       stall_w;
  logic       load_use_w;
  logic       ex_wr_w, mem_wr_w, wb_wr_w;
  logic [1:0] fwd_a_w, fwd_b_w;
  logic       byp_a_w, byp_b_w;

  // $zero is hard-wired, so a stage that targets it never produces a value.
  function automatic logic is_writer(input stage_t s);
    return s.valid && s.regwrite && (s.dest != '0);
  endfunction

  // MEM holds the younger result, so it is checked before WB.
  function automatic logic [1:0] fwd_select(input logic              uses,
                                            input logic [REG_AW-1:0] src,
                                            input logic              mem_wr,
                                            input logic [REG_AW-1:0] mem_dest,
                                            input logic              wb_wr,
                                            input logic [REG_AW-1:0] wb_dest);
    if (uses && mem_wr && (mem_dest == src)) return SEL_MEM;
    if (uses && wb_wr && (wb_dest == src))   return SEL_WB;
    return SEL_RF;
  endfunction

  assign ex_wr_w  = is_writer(ex_q);
  assign mem_wr_w = is_writer(mem_q);
  assign wb_wr_w  = is_writer(wb_q);

  // Forwarding for the instruction sitting in EX.
  always_comb begin
    fwd_a_w = SEL_RF;
    fwd_b_w = SEL_RF;
    if (ex_q.valid) begin
      fwd_a_w = fwd_select(ex_q.uses_rs, ex_q.rs, mem_wr_w, mem_q.dest, wb_wr_w, wb_q.dest);
      fwd_b_w = fwd_select(ex_q.uses_rt, ex_q.rt, mem_wr_w, mem_q.dest, wb_wr_w, wb_q.dest);
    end
  end

  // The register file write and the ID read share an edge.
  // The ID read must see the WB data directly.
  always_comb begin
    byp_a_w = hz.id_valid && hz.id_uses_rs && wb_wr_w && (wb_q.dest == hz.id_rs);
    byp_b_w = hz.id_valid && hz.id_uses_rt && wb_wr_w && (wb_q.dest == hz.id_rt);
  end

  // A load in EX has no data until MEM.
  // A dependent instruction in ID waits one cycle.
  // A redirect squashes the ID instruction anyway, so it wins over the stall.
  always_comb begin
    load_use_w = ex_wr_w && ex_q.memread &&
                 ((hz.id_uses_rs && (hz.id_rs == ex_q.dest)) ||
                  (hz.id_uses_rt && (hz.id_rt == ex_q.dest)));
    stall_w    = hz.id_valid && !hz.ex_redirect && load_use_w;
  end

  // ID -> EX transfer, with a bubble on stall or redirect.
  always_comb begin
    ex_d = '0;
    if (!stall_w && !hz.ex_redirect) begin
      ex_d.valid    = hz.id_valid;
      ex_d.rs       = hz.id_rs;
      ex_d.rt       = hz.id_rt;
      ex_d.uses_rs  = hz.id_uses_rs;
      ex_d.uses_rt  = hz.id_uses_rt;
      ex_d.dest     = hz.id_dest;
      ex_d.regwrite = hz.id_regwrite;
      ex_d.memread  = hz.id_memread;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_w && (stall_cnt_q != '1))        stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (hz.ex_redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // The full record is carried down the pipe for debug visibility.
  // Later stages only consult valid/regwrite/dest.
  logic unused_stage_bits;
  assign unused_stage_bits = ^{mem_q.rs, mem_q.rt, mem_q.uses_rs, mem_q.uses_rt, mem_q.memread,
                               wb_q.rs, wb_q.rt, wb_q.uses_rs, wb_q.uses_rt, wb_q.memread};

  assign hz.fwd_a_sel   = fwd_a_w;
  assign hz.fwd_b_sel   = fwd_b_w;
  assign hz.id_bypass_a = byp_a_w;
  assign hz.id_bypass_b = byp_b_w;
  assign hz.stall       = stall_w;
  assign hz.flush_ifid  = hz.ex_redirect;
  assign hz.flush_idex  = hz.ex_redirect;
  assign hz.stall_count = stall_cnt_q;
  assign hz.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed vector bench for hazard_forward_unit

module tb_hazard_forward_unit;

  localparam int AW = 5;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hazard_forward_unit_if #(.REG_AW(AW), .CNT_W(CW)) hz ();

  hazard_forward_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          urs;
    logic          urt;
    logic [AW-1:0] dst;
    logic          rw;
    logic          mr;
  } id_t;

  typedef struct {
    id_t        id;
    logic       rd;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       ba;
    logic       bb;
    logic       st;
    logic       fl;
    int         sc;
    int         fc;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic id_t mk_id(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                                input logic urs, input logic urt,
                                input logic [AW-1:0] dst, input logic rw, input logic mr);
    id_t r;
    r.valid = 1'b1; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt;
    r.dst = dst; r.rw = rw; r.mr = mr;
    return r;
  endfunction

  function automatic vec_t row(input id_t id, input logic rd, input logic [1:0] fa,
                               input logic [1:0] fb, input logic ba, input logic bb,
                               input logic st, input logic fl, input int sc, input int fc);
    vec_t v;
    v.id = id; v.rd = rd; v.fa = fa; v.fb = fb; v.ba = ba; v.bb = bb;
    v.st = st; v.fl = fl; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s [step %0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic apply(input id_t id, input logic rd);
    hz.id_valid    = id.valid;
    hz.id_rs       = id.rs;
    hz.id_rt       = id.rt;
    hz.id_uses_rs  = id.urs;
    hz.id_uses_rt  = id.urt;
    hz.id_dest     = id.dst;
    hz.id_regwrite = id.rw;
    hz.id_memread  = id.mr;
    hz.ex_redirect = rd;
  endtask

  task automatic check_quiet(input string tag, input int idx);
    check({tag, " fwd_a"}, idx, int'(hz.fwd_a_sel), 0);
    check({tag, " fwd_b"}, idx, int'(hz.fwd_b_sel), 0);
    check({tag, " byp_a"}, idx, int'(hz.id_bypass_a), 0);
    check({tag, " byp_b"}, idx, int'(hz.id_bypass_b), 0);
    check({tag, " stall"}, idx, int'(hz.stall), 0);
  endtask

  vec_t tbl[24];

  initial begin
    id_t bub, addi7, add_t2, rd_t1, lw_t1, sub_t3, addi_t1, add_t4, lw_z, use_z;
    bub     = '0;
    addi7   = mk_id(5'd0, 5'd9,  1'b1, 1'b0, 5'd9,  1'b1, 1'b0);
    add_t2  = mk_id(5'd9, 5'd9,  1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    rd_t1   = mk_id(5'd9, 5'd9,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0);
    lw_t1   = mk_id(5'd0, 5'd9,  1'b1, 1'b0, 5'd9,  1'b1, 1'b1);
    sub_t3  = mk_id(5'd9, 5'd10, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
    addi_t1 = mk_id(5'd9, 5'd9,  1'b1, 1'b0, 5'd9,  1'b1, 1'b0);
    add_t4  = mk_id(5'd9, 5'd0,  1'b1, 1'b1, 5'd12, 1'b1, 1'b0);
    lw_z    = mk_id(5'd0, 5'd0,  1'b1, 1'b0, 5'd0,  1'b1, 1'b1);
    use_z   = mk_id(5'd0, 5'd0,  1'b1, 1'b1, 5'd13, 1'b1, 1'b0);

    //                  id       rd    fa     fb    ba    bb    st    fl   sc fc
    // back-to-back ALU dependency, then WB->ID bypass
    tbl[0]  = row(addi7,   1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    tbl[1]  = row(add_t2,  1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    tbl[2]  = row(bub,     1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    tbl[3]  = row(rd_t1,   1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    tbl[4]  = row(bub,     1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    tbl[5]  = row(bub,     1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    // load-use: one bubble, then WB forwarding
    tbl[6]  = row(lw_t1,   1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    tbl[7]  = row(sub_t3,  1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    tbl[8]  = row(sub_t3,  1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    tbl[9]  = row(bub,     1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    tbl[10] = row(bub,     1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    // MEM wins over WB
    tbl[11] = row(addi_t1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    tbl[12] = row(addi_t1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    tbl[13] = row(add_t4,  1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    tbl[14] = row(bub,     1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    tbl[15] = row(bub,     1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    // $zero is never a hazard source
    tbl[16] = row(lw_z,    1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    tbl[17] = row(use_z,   1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    tbl[18] = row(use_z,   1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    tbl[19] = row(use_z,   1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    tbl[20] = row(bub,     1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    // redirect overrides a load-use stall
    tbl[21] = row(lw_t1,   1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0);
    tbl[22] = row(sub_t3,  1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0);
    tbl[23] = row(sub_t3,  1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1);

    reset = 1'b1;
    apply(bub, 1'b0);
    #1;
    check_quiet("reset", -1);
    check("reset stall_count", -1, int'(hz.stall_count), 0);
    check("reset flush_count", -1, int'(hz.flush_count), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 24; i++) begin
      apply(tbl[i].id, tbl[i].rd);
      #1;
      check("fwd_a_sel",   i, int'(hz.fwd_a_sel),   int'(tbl[i].fa));
      check("fwd_b_sel",   i, int'(hz.fwd_b_sel),   int'(tbl[i].fb));
      check("id_bypass_a", i, int'(hz.id_bypass_a), int'(tbl[i].ba));
      check("id_bypass_b", i, int'(hz.id_bypass_b), int'(tbl[i].bb));
      check("stall",       i, int'(hz.stall),       int'(tbl[i].st));
      check("flush_ifid",  i, int'(hz.flush_ifid),  int'(tbl[i].fl));
      check("flush_idex",  i, int'(hz.flush_idex),  int'(tbl[i].fl));
      check("stall_count", i, int'(hz.stall_count), tbl[i].sc);
      check("flush_count", i, int'(hz.flush_count), tbl[i].fc);
      @(negedge clk);
    end

    // Asynchronous reset while a load-use stall is active.
    apply(lw_t1, 1'b0);
    @(negedge clk);
    apply(sub_t3, 1'b0);
    #1;
    check("pre-reset stall", 100, int'(hz.stall), 1);
    #2;
    reset = 1'b1;
    #1;
    check_quiet("async reset", 101);
    check("async reset stall_count", 101, int'(hz.stall_count), 0);
    check("async reset flush_count", 101, int'(hz.flush_count), 0);
    @(negedge clk);
    reset = 1'b0;
    apply(sub_t3, 1'b0);
    #1;
    check("post-reset stall", 102, int'(hz.stall), 0);
    @(negedge clk);
    apply(bub, 1'b0);
    #1;
    check("post-reset fwd_a", 103, int'(hz.fwd_a_sel), 0);
    check("post-reset fwd_b", 103, int'(hz.fwd_b_sel), 0);
    check("post-reset stall_count", 103, int'(hz.stall_count), 0);

    // Counter saturation: 20 redirects into a 4-bit counter.
    @(negedge clk);
    apply(bub, 1'b1);
    repeat (20) @(negedge clk);
    apply(bub, 1'b0);
    #1;
    check("flush_count saturated", 104, int'(hz.flush_count), 15);
    check("stall_count after flushes", 104, int'(hz.stall_count), 0);
    check("flush_ifid released", 104, int'(hz.flush_ifid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
Pipeline control block for the five-stage pipelined CPU; sits beside the ID/EX/MEM/WB datapath.
- Keeps its own shadow copy of the destination and control info for the instructions in EX, MEM and WB.
- Drives the ALU operand forwarding muxes, the ID-stage register-file bypass, the load-use stall and the branch/jump flush.
- Provides saturating stall and flush counters for the cpu_test benches to check.

Parameters:
REG_AW, 5, register address width
CNT_W, 16, width of the perf counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rs  in  REG_AW  rs field of the instruction in ID
id_rt  in  REG_AW  rt field of the instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_dest  in  REG_AW  destination register of the ID instruction (rd or rt, already muxed)
id_regwrite  in  1  ID instruction writes the register file
id_memread  in  1  ID instruction is LW
ex_redirect  in  1  taken BNE/BEQ, J, JAL or JR resolved in EX this cycle
fwd_a_sel  out  2  EX operand A select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
fwd_b_sel  out  2  EX operand B select, same encoding
id_bypass_a  out  1  ID rs read takes the WB write data
id_bypass_b  out  1  ID rt read takes the WB write data
stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX
flush_ifid  out  1  clear IF/ID
flush_idex  out  1  clear ID/EX
stall_count  out  CNT_W  number of stall cycles, saturating
flush_count  out  CNT_W  number of redirect events, saturating

Behaviour:
Interface:
- One clock, clk. reset is asynchronous and active-high.

Shadow stages and reset:
- Three shadow stages: EX, MEM, WB.
- Each stage holds: valid, rs, rt, uses_rs, uses_rt, dest, regwrite, memread.
- reset clears all valid bits and both counters immediately. All outputs then read 0.

Clock update (rising edge):
- WB <= MEM; MEM <= EX.
- EX <= bubble (valid=0) if stall or ex_redirect is high; otherwise EX <= the ID inputs.

Effective writer:
- A stage counts as a writer only if valid && regwrite && dest != 0. Register $zero is never forwarded, bypassed or stalled on.

Forwarding (combinational from shadow state, for the instruction in EX):
- fwd_a_sel = 01 if EX.uses_rs && MEM is a writer && MEM.dest == EX.rs.
- Else fwd_a_sel = 10 if the same test passes against WB.
- Else fwd_a_sel = 00.
- MEM has priority over WB when both match.
- fwd_b_sel: same rules using rt and uses_rt.
- Both selects are 00 when EX.valid = 0.

ID bypass:
- id_bypass_a = id_valid && id_uses_rs && WB is a writer && WB.dest == id_rs.
- id_bypass_b: same rule using rt.
- Covers the case where the register file write and the ID read land on the same edge.

Load-use stall:
- stall = id_valid && !ex_redirect && EX is a writer && EX.memread && (id_uses_rs && id_rs == EX.dest || id_uses_rt && id_rt == EX.dest).
- Exactly one bubble per load-use hazard. On the next cycle the load is in MEM, so stall drops and forwarding returns 10 one cycle later.

Redirect:
- flush_ifid = flush_idex = ex_redirect.
- Redirect overrides stall: stall is forced to 0 in that cycle.
- Instructions already in MEM and WB are unaffected.

Counters (saturate at all-ones, no wrap):
- stall_count increments on each edge where stall = 1.
- flush_count increments on each edge where ex_redirect = 1.

Reset mid-operation:
- Any in-flight hazard is discarded.
- After reset deasserts, the first valid instruction reaches EX with fwd_*_sel = 00.

Test Plan:
1. addi $t1,$zero,7 then add $t2,$t1,$t1 back-to-back -> add in EX shows fwd_a_sel = fwd_b_sel = 01; no stall; $t2 = 0xe.
2. lw $t1,0($zero) then sub $t3,$t1,$t2 -> stall = 1 for exactly one cycle; sub in EX shows fwd_a_sel = 10; stall_count = 1.
3. addi $t1,1 then addi $t1,2 then add $t4,$t1,$zero -> fwd_a_sel = 01 (MEM wins over WB); $t4 holds the second result.
4. Producer writes $zero, followed by a consumer of $zero -> all selects 00, stall = 0, bypass = 0.
5. lw hazard in ID while ex_redirect = 1 in the same cycle -> stall = 0, both flushes = 1, next EX is a bubble, flush_count = 1, stall_count unchanged.
6. reset pulsed while stall = 1 -> all outputs 0 asynchronously; counters 0; the forwarding2 program then completes with $t1=7, $t2=2, $t3=0xffffffff, $t4=8, $t5=8, $t6=0xfffffffe.
